// File: rtl/softmax_channel_scanner.sv
// softmax_channel_scanner: snapshots NUM_CH channels on start and streams them out
// one per accepted beat; SCANNER_MAX_TRACK_EN adds a signed running max.
module softmax_channel_scanner #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 100,
    parameter int IDX_W      = $clog2(NUM_CH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_bus,
    output logic                         busy,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [IDX_W-1:0]             out_idx,
    output logic                         out_last,
    output logic                         done,
    output logic [DATA_WIDTH-1:0]        max_out,
    output logic                         max_valid
);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH);
    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(1);

    state_t                       state;
    logic [NUM_CH*DATA_WIDTH-1:0] snap;
    logic [IDX_W-1:0]             next_idx;
    logic                         load;
    logic                         xfer;

    assign load     = (state == IDLE) && start;
    assign xfer     = out_valid && out_ready;
    assign next_idx = out_idx + 1'b1;

    // Snapshot keeps in_bus layout so channel k sits at [k*DATA_WIDTH-1 -: DATA_WIDTH].
    always_ff @(posedge clk) begin
        if (load) begin
            snap <= in_bus;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state     <= STREAM;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                        out_idx   <= FIRST_IDX;
                        out_data  <= in_bus[DATA_WIDTH-1:0];
                        out_last  <= (NUM_CH == 1);
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        if (out_last) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            out_idx   <= '0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            out_idx  <= next_idx;
                            out_data <= snap[int'(next_idx)*DATA_WIDTH-1 -: DATA_WIDTH];
                            out_last <= (next_idx == LAST_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SCANNER_MAX_TRACK_EN
    // Beat 1 seeds the max, so a stale value from the previous scan never leaks in.
    always_ff @(posedge clk) begin
        if (rst) begin
            max_out   <= '0;
            max_valid <= 1'b0;
        end else begin
            max_valid <= xfer && out_last;
            if (xfer && ((out_idx == FIRST_IDX) ||
                         ($signed(out_data) > $signed(max_out)))) begin
                max_out <= out_data;
            end
        end
    end
`else
    assign max_out   = '0;
    assign max_valid = 1'b0;
`endif

endmodule

// File: tb/tb_softmax_channel_scanner.sv
// Directed bench for softmax_channel_scanner: scan, backpressure, snapshot,
// reset abort, back-to-back and the optional running max on a 4-channel instance.
module tb_softmax_channel_scanner;

    localparam int DW = 16;
    localparam int NC = 100;
    localparam int IW = $clog2(NC + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [NC*DW-1:0] in_bus;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_data;
    logic [IW-1:0]    out_idx;
    logic             out_last;
    logic             done;
    logic [DW-1:0]    max_out;
    logic             max_valid;

    logic             s_start;
    logic [4*DW-1:0]  s_bus;
    logic             s_busy;
    logic             s_valid;
    logic             s_ready;
    logic [DW-1:0]    s_data;
    logic [2:0]       s_idx;
    logic             s_last;
    logic             s_done;
    logic [DW-1:0]    s_max;
    logic             s_max_valid;

    softmax_channel_scanner #(.DATA_WIDTH(DW), .NUM_CH(NC)) dut (
        .clk(clk), .rst(rst), .start(start), .in_bus(in_bus),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
        .done(done), .max_out(max_out), .max_valid(max_valid)
    );

    softmax_channel_scanner #(.DATA_WIDTH(DW), .NUM_CH(4)) dut4 (
        .clk(clk), .rst(rst), .start(s_start), .in_bus(s_bus),
        .busy(s_busy), .out_valid(s_valid), .out_ready(s_ready),
        .out_data(s_data), .out_idx(s_idx), .out_last(s_last),
        .done(s_done), .max_out(s_max), .max_valid(s_max_valid)
    );

    always #5 clk = ~clk;

`ifdef SCANNER_MAX_TRACK_EN
    localparam logic [31:0] EXP_MAX = 32'h7FFF;
    localparam logic [31:0] EXP_MV  = 32'd1;
`else
    localparam logic [31:0] EXP_MAX = 32'h0;
    localparam logic [31:0] EXP_MV  = 32'd0;
`endif

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_k3();
        for (int k = 1; k <= NC; k++) in_bus[k*DW-1 -: DW] = DW'(k * 3);
    endtask

    // Streams from the currently visible beat k0 with out_ready=1 up to the done cycle.
    task automatic drain(input int k0, input string tag);
        int k;
        int cyc;
        k = k0;
        cyc = 0;
        out_ready = 1'b1;
        while (!done && cyc < 400) begin
            if (out_valid) begin
                check({tag, "_idx"}, out_idx, k);
                check({tag, "_data"}, out_data, k * 3);
                check({tag, "_last"}, out_last, (k == NC));
                k++;
            end
            step();
            cyc++;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_count"}, k, NC + 1);
        check({tag, "_valid_end"}, out_valid, 0);
        check({tag, "_busy_end"}, busy, 0);
    endtask

    initial begin
        int k;
        int cyc;
        int dones;
        bit held;
        bit ph;
        bit r;
        logic [DW-1:0] sv [4];

        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        s_start = 1'b0;
        s_ready = 1'b1;
        s_bus = {16'h000C, 16'h8000, 16'h7FFF, 16'hFFFB};
        sv = '{16'hFFFB, 16'h7FFF, 16'h8000, 16'h000C};
        fill_k3();
        step();
        step();
        rst = 1'b0;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_idx", out_idx, 0);
        check("rst_data", out_data, 0);
        check("rst_last", out_last, 0);
        check("rst_done", done, 0);
        check("rst_max", max_out, 0);
        check("rst_maxv", max_valid, 0);

        // basic scan
        start = 1'b1;
        step();
        start = 1'b0;
        check("t1_busy", busy, 1);
        drain(1, "t1");
        check("t1_idle_idx", out_idx, 0);
        check("t1_idle_data", out_data, 0);
        step();
        check("t1_done_pulse", done, 0);

        // backpressure: 1010.. plus a 5-cycle hold on beat 50
        start = 1'b1;
        step();
        start = 1'b0;
        k = 1;
        cyc = 0;
        held = 1'b0;
        ph = 1'b0;
        while (!done && cyc < 1000) begin
            if (out_valid && out_idx == IW'(50) && !held) begin
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    step();
                    check("t2_hold_valid", out_valid, 1);
                    check("t2_hold_idx", out_idx, 50);
                    check("t2_hold_data", out_data, 150);
                end
                held = 1'b1;
            end
            r = ~ph;
            ph = ~ph;
            out_ready = r;
            if (out_valid && r) begin
                check("t2_idx", out_idx, k);
                check("t2_data", out_data, k * 3);
                k++;
            end
            step();
            cyc++;
        end
        check("t2_count", k, NC + 1);
        check("t2_done", done, 1);
        check("t2_held", held, 1);
        out_ready = 1'b1;

        // snapshot and start-while-busy
        start = 1'b1;
        step();
        start = 1'b0;
        k = 1;
        cyc = 0;
        dones = 0;
        while (!done && cyc < 400) begin
            start = 1'b0;
            if (out_valid) begin
                check("t3_idx", out_idx, k);
                check("t3_data", out_data, k * 3);
                if (k == 20) begin
                    in_bus = '1;
                    start = 1'b1;
                end
                k++;
            end
            step();
            cyc++;
        end
        start = 1'b0;
        check("t3_count", k, NC + 1);
        for (int s = 0; s < 6; s++) begin
            if (done) dones++;
            if (s > 0) check("t3_no_restart", out_valid, 0);
            step();
        end
        check("t3_dones", dones, 1);
        fill_k3();

        // reset at idx 37, restart next cycle
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 0;
        while (out_idx != IW'(37) && cyc < 200) begin
            step();
            cyc++;
        end
        check("t4_reach37", out_idx, 37);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t4_valid0", out_valid, 0);
        check("t4_busy0", busy, 0);
        check("t4_idx0", out_idx, 0);
        check("t4_data0", out_data, 0);
        check("t4_done0", done, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("t4_restart_done", done, 0);
        check("t4_restart_valid", out_valid, 1);
        drain(1, "t4");

        // back-to-back: start in the done cycle
        start = 1'b1;
        step();
        start = 1'b0;
        check("t5_done_gone", done, 0);
        check("t5_valid", out_valid, 1);
        check("t5_busy", busy, 1);
        check("t5_idx", out_idx, 1);
        check("t5_data", out_data, 3);
        drain(1, "t5");

        // signed running max on a 4-channel instance
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        for (int b = 1; b <= 4; b++) begin
            check("t6_valid", s_valid, 1);
            check("t6_idx", s_idx, b);
            check("t6_data", s_data, sv[b-1]);
            check("t6_last", s_last, (b == 4));
            step();
        end
        check("t6_done", s_done, 1);
        check("t6_max", s_max, EXP_MAX);
        check("t6_maxv", s_max_valid, EXP_MV);
        step();
        check("t6_maxv_pulse", s_max_valid, 0);
        check("t6_max_hold", s_max, EXP_MAX);
        check("t6_done_pulse", s_done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
